// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } state_t;

  localparam logic [7:0]  DEFAULT_HEADER = 8'hAA;
  localparam int unsigned LEN_W          = 8;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: one write port, registered read that returns zero past the held length.
module uart_frame_buf
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned AW     = addr_w(MAX_LEN)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [AW-1:0]    i_raddr,
  input  logic [LEN_W-1:0] i_len,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [MAX_LEN];
  logic [7:0] r_rdata;

  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset)                         r_rdata <= '0;
    else if (LEN_W'(i_raddr) < i_len)  r_rdata <= r_mem[i_raddr];
    else                               r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_parser.sv
// Frame decoder HEADER, LEN, payload, CHK with held-payload readout.
// Optional inter-byte timeout enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic [7:0]                 Rx_data,
  input  logic                       Rx_valid,
  output logic                       Frame_valid,
  output logic [7:0]                 Frame_len,
  input  logic [addr_w(MAX_LEN)-1:0] Rd_addr,
  output logic [7:0]                 Rd_data,
  input  logic                       Frame_ack,
  output logic                       Err_len,
  output logic                       Err_chk,
  output logic                       Overrun,
  output logic                       Err_timeout
);

  localparam int unsigned AW      = addr_w(MAX_LEN);
  localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);

  state_t     r_state, w_next;
  logic       r_rv_d;
  logic       w_stb;
  logic [7:0] r_len, r_sum, r_idx;
  logic       w_len_ok, w_we, w_chk_ok, w_err_len, w_err_chk, w_overrun, w_timeout;
  logic       r_frame_valid, r_err_len, r_err_chk, r_overrun, r_err_to;
  logic [7:0] r_frame_len;

  // rv_d resets high so a level already asserted at reset release is not a byte
  assign w_stb    = Rx_valid & ~r_rv_d;
  assign w_len_ok = (Rx_data != 8'h00) && (Rx_data <= LEN_MAX);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned GW      = $clog2(TIMEOUT_CYC);
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC - 1);

  logic [GW-1:0] r_gap;
  logic          w_active;

  assign w_active  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHK);
  assign w_timeout = w_active && !w_stb && (r_gap == GAP_MAX);

  always_ff @(posedge Clk) begin
    if (Reset || w_stb || !w_active || w_timeout) r_gap <= '0;
    else                                          r_gap <= r_gap + GW'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_rv_d  <= 1'b1;
      r_len   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_rv_d  <= Rx_valid;
      if (w_stb && r_state == ST_LEN && w_len_ok) begin
        r_len <= Rx_data;
        r_sum <= Rx_data;
        r_idx <= '0;
      end else if (w_we) begin
        r_sum <= r_sum + Rx_data;
        r_idx <= r_idx + 8'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_stb && Rx_data == HEADER)          w_next = ST_LEN;
      ST_LEN:     if (w_stb)                               w_next = w_len_ok ? ST_PAYLOAD : ST_IDLE;
      ST_PAYLOAD: if (w_stb && r_idx == r_len - 8'd1)      w_next = ST_CHK;
      ST_CHK:     if (w_stb)                               w_next = (Rx_data == r_sum) ? ST_HOLD : ST_IDLE;
      ST_HOLD:    if (Frame_ack)                           w_next = ST_IDLE;
      default:                                             w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  always_comb begin
    w_we      = w_stb && (r_state == ST_PAYLOAD);
    w_err_len = w_stb && (r_state == ST_LEN) && !w_len_ok;
    w_chk_ok  = w_stb && (r_state == ST_CHK) && (Rx_data == r_sum);
    w_err_chk = w_stb && (r_state == ST_CHK) && (Rx_data != r_sum);
    w_overrun = w_stb && (r_state == ST_HOLD);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_valid <= 1'b0;
      r_frame_len   <= '0;
      r_err_len     <= 1'b0;
      r_err_chk     <= 1'b0;
      r_overrun     <= 1'b0;
      r_err_to      <= 1'b0;
    end else begin
      r_err_len <= w_err_len;
      r_err_chk <= w_err_chk;
      r_overrun <= w_overrun;
      r_err_to  <= w_timeout;
      if (w_chk_ok) begin
        r_frame_valid <= 1'b1;
        r_frame_len   <= r_len;
      end else if (r_state == ST_HOLD && Frame_ack) begin
        r_frame_valid <= 1'b0;
        r_frame_len   <= '0;
      end
    end
  end

  uart_frame_buf #(
    .MAX_LEN(MAX_LEN)
  ) u_buf (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (w_we),
    .i_waddr (r_idx[AW-1:0]),
    .i_wdata (Rx_data),
    .i_raddr (Rd_addr),
    .i_len   (r_frame_len),
    .o_rdata (Rd_data)
  );

  assign Frame_valid = r_frame_valid;
  assign Frame_len   = r_frame_len;
  assign Err_len     = r_err_len;
  assign Err_chk     = r_err_chk;
  assign Overrun     = r_overrun;
  assign Err_timeout = r_err_to;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser; checksum covers LEN plus payload bytes.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN     = 16;
  localparam int unsigned TIMEOUT_CYC = 100;

  logic       Clk = 1'b0;
  logic       Reset, Rx_valid, Frame_ack;
  logic [7:0] Rx_data;
  logic [3:0] Rd_addr;
  logic       Frame_valid, Err_len, Err_chk, Overrun, Err_timeout;
  logic [7:0] Frame_len, Rd_data;

  always #5 Clk = ~Clk;

  uart_frame_parser #(
    .MAX_LEN    (MAX_LEN),
    .HEADER     (8'hAA),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Rx_data    (Rx_data),
    .Rx_valid   (Rx_valid),
    .Frame_valid(Frame_valid),
    .Frame_len  (Frame_len),
    .Rd_addr    (Rd_addr),
    .Rd_data    (Rd_data),
    .Frame_ack  (Frame_ack),
    .Err_len    (Err_len),
    .Err_chk    (Err_chk),
    .Overrun    (Overrun),
    .Err_timeout(Err_timeout)
  );

  int total = 0;
  int bad   = 0;
  int n_len = 0, n_chk = 0, n_ovr = 0, n_to = 0;
  int e_len = 0, e_chk = 0, e_ovr = 0, e_to = 0;
  logic [7:0] seq[$];

  always @(negedge Clk) begin
    if (Err_len)     n_len++;
    if (Err_chk)     n_chk++;
    if (Overrun)     n_ovr++;
    if (Err_timeout) n_to++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    Rx_data  = b;
    Rx_valid = 1'b1;
    @(posedge Clk); #1;
    Rx_valid = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i]);
  endtask

  task automatic settle();
    repeat (2) @(posedge Clk);
    #1;
  endtask

  task automatic read_at(input logic [3:0] a);
    Rd_addr = a;
    @(posedge Clk); #1;
  endtask

  task automatic do_ack();
    Frame_ack = 1'b1;
    @(posedge Clk); #1;
    Frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Rx_valid = 1'b1; Rx_data = 8'hAA; Frame_ack = 1'b0; Rd_addr = '0;
    repeat (3) @(posedge Clk); #1;
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", Frame_valid); end
    total++; if (Frame_len !== 8'h00) begin bad++; $display("FAIL reset_len got=%h exp=00", Frame_len); end
    total++; if (Rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", Rd_data); end
    total++; if ({Err_len, Err_chk, Overrun, Err_timeout} !== 4'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=0000", {Err_len, Err_chk, Overrun, Err_timeout}); end
    Reset = 1'b0;
    repeat (3) @(posedge Clk); #1;
    Rx_valid = 1'b0;
    seq = '{8'hAA, 8'h01, 8'h07, 8'h08};
    send_seq(); settle();
    total++; if (n_len !== e_len) begin bad++; $display("FAIL held_valid_errlen got=%0d exp=%0d", n_len, e_len); end
    total++; if (Frame_valid !== 1'b1) begin bad++; $display("FAIL held_valid_fv got=%b exp=1", Frame_valid); end
    read_at(4'd0);
    total++; if (Rd_data !== 8'h07) begin bad++; $display("FAIL held_valid_rd0 got=%h exp=07", Rd_data); end
    do_ack();
  endtask

  task automatic test_basic_frame();
    seq = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL basic_early_fv got=%b exp=0", Frame_valid); end
    send_byte(8'h69);
    total++; if (Frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b exp=1", Frame_valid); end
    total++; if (Frame_len !== 8'd3) begin bad++; $display("FAIL basic_len got=%0d exp=3", Frame_len); end
    read_at(4'd0);
    total++; if (Rd_data !== 8'h11) begin bad++; $display("FAIL basic_rd0 got=%h exp=11", Rd_data); end
    read_at(4'd1);
    total++; if (Rd_data !== 8'h22) begin bad++; $display("FAIL basic_rd1 got=%h exp=22", Rd_data); end
    read_at(4'd2);
    total++; if (Rd_data !== 8'h33) begin bad++; $display("FAIL basic_rd2 got=%h exp=33", Rd_data); end
    read_at(4'd3);
    total++; if (Rd_data !== 8'h00) begin bad++; $display("FAIL basic_rd3_oor got=%h exp=00", Rd_data); end
    do_ack();
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL basic_ack_fv got=%b exp=0", Frame_valid); end
  endtask

  task automatic test_chk_error();
    seq = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h31};
    send_seq(); settle(); e_chk++;
    total++; if (n_chk !== e_chk) begin bad++; $display("FAIL chk_err_count got=%0d exp=%0d", n_chk, e_chk); end
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL chk_err_fv got=%b exp=0", Frame_valid); end
    seq = '{8'hAA, 8'h02, 8'h10, 8'h20, 8'h32};
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd2) begin
      bad++; $display("FAIL chk_next_frame got=%b/%0d exp=1/2", Frame_valid, Frame_len); end
    read_at(4'd1);
    total++; if (Rd_data !== 8'h20) begin bad++; $display("FAIL chk_next_rd1 got=%h exp=20", Rd_data); end
    do_ack();
  endtask

  task automatic test_len_and_sync();
    seq = '{8'hAA, 8'h00, 8'hAA, 8'h11};
    send_seq(); settle(); e_len += 2;
    total++; if (n_len !== e_len) begin bad++; $display("FAIL len_err_count got=%0d exp=%0d", n_len, e_len); end
    seq = '{8'h55, 8'hAA, 8'h01, 8'h55, 8'h56};
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd1) begin
      bad++; $display("FAIL sync_frame got=%b/%0d exp=1/1", Frame_valid, Frame_len); end
    read_at(4'd0);
    total++; if (Rd_data !== 8'h55) begin bad++; $display("FAIL sync_rd0 got=%h exp=55", Rd_data); end
    do_ack();
    // Maximum length: payload 01..10, checksum 10 + 88 = 98
    seq = '{8'hAA, 8'h10};
    for (int i = 1; i <= 16; i++) seq.push_back(8'(i));
    seq.push_back(8'h98);
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd16) begin
      bad++; $display("FAIL maxlen_frame got=%b/%0d exp=1/16", Frame_valid, Frame_len); end
    read_at(4'd15);
    total++; if (Rd_data !== 8'h10) begin bad++; $display("FAIL maxlen_rd15 got=%h exp=10", Rd_data); end
    do_ack();
    seq = '{8'hAA, 8'h02, 8'hAA, 8'hAA, 8'h56};
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd2) begin
      bad++; $display("FAIL hdr_in_payload got=%b/%0d exp=1/2", Frame_valid, Frame_len); end
    read_at(4'd1);
    total++; if (Rd_data !== 8'hAA) begin bad++; $display("FAIL hdr_in_payload_rd1 got=%h exp=aa", Rd_data); end
  endtask

  task automatic test_overrun();
    seq = '{8'hAA, 8'h01, 8'h05, 8'h06};
    send_seq(); settle(); e_ovr += 4;
    total++; if (n_ovr !== e_ovr) begin bad++; $display("FAIL ovr_count got=%0d exp=%0d", n_ovr, e_ovr); end
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd2) begin
      bad++; $display("FAIL ovr_hold got=%b/%0d exp=1/2", Frame_valid, Frame_len); end
    read_at(4'd0);
    total++; if (Rd_data !== 8'hAA) begin bad++; $display("FAIL ovr_buf_rd0 got=%h exp=aa", Rd_data); end
    @(posedge Clk); #1;
    Rx_data = 8'hAA; Rx_valid = 1'b1; Frame_ack = 1'b1;
    @(posedge Clk); #1;
    Rx_valid = 1'b0; Frame_ack = 1'b0;
    seq = '{8'h01, 8'h05, 8'h06};
    send_seq(); settle(); e_ovr++;
    total++; if (n_ovr !== e_ovr) begin bad++; $display("FAIL ack_stb_ovr got=%0d exp=%0d", n_ovr, e_ovr); end
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL ack_stb_dropped got=%b exp=0", Frame_valid); end
    seq = '{8'hAA, 8'h01, 8'h05, 8'h06};
    send_seq(); settle();
    read_at(4'd0);
    total++; if (Frame_valid !== 1'b1 || Rd_data !== 8'h05) begin
      bad++; $display("FAIL resend got=%b/%h exp=1/05", Frame_valid, Rd_data); end
    do_ack();
  endtask

  task automatic test_reset_mid_frame();
    seq = '{8'hAA, 8'h04, 8'h11};
    send_seq();
    Reset = 1'b1;
    repeat (2) @(posedge Clk); #1;
    Reset = 1'b0;
    settle();
    total++; if (Frame_valid !== 1'b0 || n_len !== e_len || n_chk !== e_chk) begin
      bad++; $display("FAIL rst_mid_quiet got=%b/%0d/%0d exp=0/%0d/%0d", Frame_valid, n_len, n_chk, e_len, e_chk); end
    seq = '{8'hAA, 8'h01, 8'h05, 8'h06};
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd1) begin
      bad++; $display("FAIL rst_mid_next got=%b/%0d exp=1/1", Frame_valid, Frame_len); end
    do_ack();
  endtask

  task automatic test_timeout();
    seq = '{8'hAA, 8'h04, 8'h11};
    send_seq();
    repeat (110) @(posedge Clk); #1;
    seq = '{8'h22, 8'h33, 8'h44, 8'hAE};
`ifdef FRAME_TIMEOUT_EN
    e_to++;
    total++; if (n_to !== e_to) begin bad++; $display("FAIL timeout_count got=%0d exp=%0d", n_to, e_to); end
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b0) begin bad++; $display("FAIL timeout_abandon got=%b exp=0", Frame_valid); end
`else
    total++; if (n_to !== 0) begin bad++; $display("FAIL no_timeout_count got=%0d exp=0", n_to); end
    send_seq(); settle();
    total++; if (Frame_valid !== 1'b1 || Frame_len !== 8'd4) begin
      bad++; $display("FAIL late_frame got=%b/%0d exp=1/4", Frame_valid, Frame_len); end
    read_at(4'd3);
    total++; if (Rd_data !== 8'h44) begin bad++; $display("FAIL late_frame_rd3 got=%h exp=44", Rd_data); end
    do_ack();
`endif
    total++; if (n_len !== e_len || n_chk !== e_chk || n_ovr !== e_ovr) begin
      bad++; $display("FAIL final_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_len, n_chk, n_ovr, e_len, e_chk, e_ovr); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_chk_error();
    test_len_and_sync();
    test_overrun();
    test_reset_mid_frame();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
